matrix_scan_scheduler: RTL

Sequences the HUB75 panel datapath for one half-panel scan: walks the framebuffer read address (frame, row, column, bitplane), drives pixel clock, row latch, OE and row address, and times binary-coded-modulation (BCM) on-periods. Sits between the framebuffer read port and the panel pins in `main`. It replaces ad-hoc row/latch logic with one explicit FSM. It also owns `frame_select`, so double-buffer swaps happen only at frame boundaries.

---
 rtl/matrix_scan_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : matrix_scan_scheduler
// Description : HUB75 half-panel scan sequencer (column/row/plane walk, BCM OE
//               timing). Optional row-change blanking via ROW_DEADTIME_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module matrix_scan_scheduler #(
    parameter int PIXEL_WIDTH    = 64,
    parameter int ROW_COUNT      = 16,
    parameter int PLANES         = 8,
    parameter int BASE_ON_TICKS  = 2,
    parameter int DEADTIME_TICKS = 4,
    localparam int c_COL_W       = $clog2(PIXEL_WIDTH),
    localparam int c_PLANE_W     = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 frame_swap_req,
    output logic [c_COL_W-1:0]   column_address,
    output logic [3:0]           row_address,
    output logic [c_PLANE_W-1:0] bitplane,
    output logic                 frame_select,
    output logic                 clk_pixel,
    output logic                 row_latch,
    output logic                 output_enable_n,
    output logic [3:0]           row_address_active,
    output logic                 frame_swapped,
    output logic                 busy
);

    localparam int c_ON_W = $clog2(BASE_ON_TICKS << (PLANES - 1)) + 1;
    localparam logic [c_COL_W-1:0]   c_COL_LAST   = c_COL_W'(PIXEL_WIDTH - 1);
    localparam logic [c_PLANE_W-1:0] c_PLANE_LAST = c_PLANE_W'(PLANES - 1);
    localparam logic [3:0]           c_ROW_LAST   = 4'(ROW_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_BLANK    = 3'd2,
        S_LATCH    = 3'd3,
        S_DISPLAY  = 3'd4
`ifdef ROW_DEADTIME_EN
        , S_DEADTIME = 3'd5
`endif
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_phase, w_phase_nxt;
    logic [c_COL_W-1:0]     r_col, w_col_nxt;
    logic [3:0]             r_row, w_row_nxt;
    logic [c_PLANE_W-1:0]   r_plane, w_plane_nxt;
    logic [c_ON_W-1:0]      r_on_cnt, w_on_nxt, w_on_load;
    logic                   w_boundary;
    logic                   r_pending, r_frame_sel, r_swapped;
    logic                   r_clk_pixel, r_row_latch, r_oe_n, r_busy;
    logic [3:0]             r_row_active;

`ifdef ROW_DEADTIME_EN
    localparam int c_DEAD_W = $clog2(DEADTIME_TICKS) + 1;
    localparam logic [c_DEAD_W-1:0] c_DEAD_LOAD = c_DEAD_W'(DEADTIME_TICKS - 1);
    logic [c_DEAD_W-1:0]    r_dead_cnt, w_dead_nxt;
`endif

    // On-period of plane p is BASE_ON_TICKS << p; counter runs load..0.
    assign w_on_load = (c_ON_W'(BASE_ON_TICKS) << r_plane) - c_ON_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_plane_nxt = r_plane;
        w_on_nxt    = r_on_cnt;
        w_boundary  = 1'b0;
`ifdef ROW_DEADTIME_EN
        w_dead_nxt  = r_dead_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_SHIFT;
                    w_phase_nxt = 1'b0;
                    w_col_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (r_col == c_COL_LAST) begin
                        w_state_nxt = S_BLANK;
                    end else begin
                        w_col_nxt = r_col + c_COL_W'(1);
                    end
                end
            end
            S_BLANK: begin
`ifdef ROW_DEADTIME_EN
                if (r_plane == '0) begin
                    w_state_nxt = S_DEADTIME;
                    w_dead_nxt  = c_DEAD_LOAD;
                end else
`endif
                w_state_nxt = S_LATCH;
            end
`ifdef ROW_DEADTIME_EN
            S_DEADTIME: begin
                if (r_dead_cnt == '0) begin
                    w_state_nxt = S_LATCH;
                end else begin
                    w_dead_nxt = r_dead_cnt - c_DEAD_W'(1);
                end
            end
`endif
            S_LATCH: begin
                w_state_nxt = S_DISPLAY;
                w_on_nxt    = w_on_load;
            end
            S_DISPLAY: begin
                if (r_on_cnt == '0) begin
                    if (r_plane == c_PLANE_LAST) begin
                        w_plane_nxt = '0;
                        if (r_row == c_ROW_LAST) begin
                            w_row_nxt  = '0;
                            w_boundary = 1'b1;
                        end else begin
                            w_row_nxt = r_row + 4'd1;
                        end
                    end else begin
                        w_plane_nxt = r_plane + c_PLANE_W'(1);
                    end
                    if (enable) begin
                        w_state_nxt = S_SHIFT;
                        w_phase_nxt = 1'b0;
                        w_col_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_on_nxt = r_on_cnt - c_ON_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pin-level outputs are decoded from the next state so they are registered
    // yet aligned with the state they describe.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_phase      <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_plane      <= '0;
            r_on_cnt     <= '0;
            r_pending    <= 1'b0;
            r_frame_sel  <= 1'b0;
            r_swapped    <= 1'b0;
            r_clk_pixel  <= 1'b0;
            r_row_latch  <= 1'b0;
            r_oe_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_row_active <= '0;
`ifdef ROW_DEADTIME_EN
            r_dead_cnt   <= '0;
`endif
        end else begin
            r_phase     <= w_phase_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_plane     <= w_plane_nxt;
            r_on_cnt    <= w_on_nxt;
`ifdef ROW_DEADTIME_EN
            r_dead_cnt  <= w_dead_nxt;
`endif
            r_clk_pixel <= (w_state_nxt == S_SHIFT) && w_phase_nxt;
            r_row_latch <= (w_state_nxt == S_LATCH);
            r_oe_n      <= (w_state_nxt != S_DISPLAY);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (r_state == S_LATCH) begin
                r_row_active <= r_row;
            end
            r_swapped <= 1'b0;
            if (w_boundary && (r_pending || frame_swap_req)) begin
                r_frame_sel <= ~r_frame_sel;
                r_swapped   <= 1'b1;
                r_pending   <= 1'b0;
            end else if (frame_swap_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign column_address     = r_col;
    assign row_address        = r_row;
    assign bitplane           = r_plane;
    assign frame_select       = r_frame_sel;
    assign clk_pixel          = r_clk_pixel;
    assign row_latch          = r_row_latch;
    assign output_enable_n    = r_oe_n;
    assign row_address_active = r_row_active;
    assign frame_swapped      = r_swapped;
    assign busy               = r_busy;

endmodule
`default_nettype wire
